// File: rtl/full_adder.sv
// Single-bit full adder with registered sum/cout and an optional bit-serial
// mode in which an internal carry flop replaces cin (operands stream LSB first).
module full_adder #(
    parameter bit SER_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    output logic sum,
    output logic cout,
    input  logic cin,
    input  logic a,
    input  logic b,
    input  logic en,
    input  logic ser,
    input  logic clr,
    output logic sum_q,
    output logic cout_q,
    output logic carry_q
);

    logic c;

    // Combinational path must not depend on the clock so instances can chain.
    assign c    = (SER_EN && ser) ? carry_q : cin;
    assign sum  = a ^ b ^ c;
    assign cout = (a & b) | (a & c) | (b & c);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= 1'b0;
            cout_q <= 1'b0;
        end else if (en) begin
            sum_q  <= sum;
            cout_q <= cout;
        end
    end

    // clr wins over en; with serial mode compiled out the carry flop stays at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (clr || !SER_EN) begin
            carry_q <= 1'b0;
        end else if (en) begin
            carry_q <= cout;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: directed scenarios plus randomized
// stimulus compared with an arithmetic reference model.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n;
    logic a, b, cin, en, ser, clr;
    logic sum, cout, sum_q, cout_q, carry_q;

    // chained pair (serial mode unused)
    logic c_a, c_b, c_cin1;
    logic sum1, cout1, sum1_q, cout1_q, carry1_q;
    logic sum2, cout2, sum2_q, cout2_q, carry2_q;

    // instance with serial mode compiled out
    logic n_a, n_b, n_cin, n_en, n_ser, n_clr;
    logic n_sum, n_cout, n_sum_q, n_cout_q, n_carry_q;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    bit m_sum_q, m_cout_q, m_carry;

    always #5 clk = ~clk;

    full_adder #(.SER_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .sum(sum), .cout(cout), .cin(cin),
        .a(a), .b(b), .en(en), .ser(ser), .clr(clr),
        .sum_q(sum_q), .cout_q(cout_q), .carry_q(carry_q)
    );

    full_adder #(.SER_EN(1'b1)) u_chain1 (
        .clk(clk), .rst_n(rst_n), .sum(sum1), .cout(cout1), .cin(c_cin1),
        .a(c_a), .b(c_b), .en(1'b0), .ser(1'b0), .clr(1'b0),
        .sum_q(sum1_q), .cout_q(cout1_q), .carry_q(carry1_q)
    );

    full_adder #(.SER_EN(1'b1)) u_chain2 (
        .clk(clk), .rst_n(rst_n), .sum(sum2), .cout(cout2), .cin(sum1),
        .a(c_a), .b(c_b), .en(1'b0), .ser(1'b0), .clr(1'b0),
        .sum_q(sum2_q), .cout_q(cout2_q), .carry_q(carry2_q)
    );

    full_adder #(.SER_EN(1'b0)) u_noser (
        .clk(clk), .rst_n(rst_n), .sum(n_sum), .cout(n_cout), .cin(n_cin),
        .a(n_a), .b(n_b), .en(n_en), .ser(n_ser), .clr(n_clr),
        .sum_q(n_sum_q), .cout_q(n_cout_q), .carry_q(n_carry_q)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Expected {cout,sum} from plain addition of the three input bits.
    function automatic logic [1:0] add3(input bit x, input bit y, input bit z);
        int t;
        t = int'(x) + int'(y) + int'(z);
        return t[1:0];
    endfunction

    // Check combinational outputs, clock once, update model, check registers.
    task automatic step(input string tag);
        logic [1:0] exp;
        exp = add3(a, b, ser ? m_carry : cin);
        #1;
        check({tag, ".comb"}, {6'd0, cout, sum}, {6'd0, exp});
        @(posedge clk);
        #1;
        if (en) begin
            m_sum_q  = exp[0];
            m_cout_q = exp[1];
        end
        if (clr)     m_carry = 1'b0;
        else if (en) m_carry = exp[1];
        check({tag, ".regs"}, {5'd0, cout_q, sum_q, carry_q},
              {5'd0, m_cout_q, m_sum_q, m_carry});
    endtask

    initial begin
        logic [1:0] exp;
        bit h_sum, h_cout, h_carry;
        int op_a, op_b, res;

        rst_n = 1'b0;
        {a, b, cin, en, ser, clr} = '0;
        {c_a, c_b, c_cin1} = '0;
        {n_a, n_b, n_cin, n_en, n_ser, n_clr} = '0;
        m_sum_q = 0; m_cout_q = 0; m_carry = 0;

        @(posedge clk);
        #1;
        check("reset_regs", {5'd0, cout_q, sum_q, carry_q}, 8'd0);

        // Truth table in order 000..111, exercised while reset is held.
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {a, b, cin} = i[2:0];
            #2;
            exp = add3(a, b, cin);
            check($sformatf("truth_%0d", i), {6'd0, cout, sum}, {6'd0, exp});
        end
        check("reset_hold", {5'd0, cout_q, sum_q, carry_q}, 8'd0);
        en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Chain: second cin is first sum.
        c_a = 1'b1; c_b = 1'b0; c_cin1 = 1'b1;
        #1;
        exp = add3(1, 0, 1);
        check("chain1", {6'd0, cout1, sum1}, {6'd0, exp});
        exp = add3(1, 0, exp[0]);
        check("chain2", {6'd0, cout2, sum2}, {6'd0, exp});

        // Serial 3+3, LSB first, after a clr pulse.
        op_a = 3; op_b = 3; res = op_a + op_b;
        ser = 1'b1; clr = 1'b1; en = 1'b0;
        step("ser_clr");
        check("ser_clr_carry", {7'd0, carry_q}, 8'd0);
        clr = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int mask;
            a = op_a[i]; b = op_b[i];
            step($sformatf("ser_bit%0d", i));
            mask = (1 << (i + 1)) - 1;
            check($sformatf("ser_sum_q%0d", i), {7'd0, sum_q}, {7'd0, res[i]});
            check($sformatf("ser_carry_q%0d", i), {7'd0, carry_q},
                  {7'd0, 1'(((op_a & mask) + (op_b & mask)) >> (i + 1))});
        end

        // Hold with en=0 while a/b change; load a carry first.
        a = 1'b1; b = 1'b1;
        step("hold_load");
        h_sum = sum_q; h_cout = cout_q; h_carry = carry_q;
        check("hold_loaded_carry", {7'd0, carry_q}, 8'd1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            {a, b} = 2'($urandom_range(0, 3));
            step($sformatf("hold%0d", i));
            check($sformatf("hold_regs%0d", i), {5'd0, cout_q, sum_q, carry_q},
                  {5'd0, h_cout, h_sum, h_carry});
        end

        // Reset mid-word, asserted between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        m_sum_q = 0; m_cout_q = 0; m_carry = 0;
        check("midword_reset", {5'd0, cout_q, sum_q, carry_q}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a = 1'b1; b = 1'b0; ser = 1'b1; en = 1'b0;
        #1;
        check("after_reset", {6'd0, cout, sum}, {6'd0, add3(1, 0, 0)});
        @(posedge clk);
        #1;

        // SER_EN=0: ser ignored, carry flop stays 0 even with carry generated.
        n_ser = 1'b1; n_cin = 1'b1; n_a = 1'b0; n_b = 1'b0; n_en = 1'b1;
        #1;
        check("noser_sum", {6'd0, n_cout, n_sum}, {6'd0, add3(0, 0, 1)});
        n_a = 1'b1; n_b = 1'b1;
        @(posedge clk);
        #1;
        check("noser_carry", {7'd0, n_carry_q}, 8'd0);
        check("noser_regs", {6'd0, n_cout_q, n_sum_q}, {6'd0, add3(1, 1, 1)});

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            a   = 1'($urandom);
            b   = 1'($urandom);
            cin = 1'($urandom);
            ser = 1'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 7) == 0);
            step($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
